mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
- Upstream sequencer and capture stage for the 8:1 mux (mux8_1).
- Drives the mux select through the enabled channels in ascending order, waits a programmable settle time on each, and samples the mux output Y.
- Packs the samples into an 8-bit frame and offers it downstream on a valid/ready handshake.
- Converts the combinational mux into a sampled, flow-controlled 8-channel snapshot source.

Parameters:
- SETTLE_CYCLES, 2: cycles each channel is held on sel before its sample is taken. Legal range 1..15; counter is 4 bits.
- AUTO_RESTART, 0: 1 = rescan immediately after a frame is accepted, using the latched mask. 0 = return to IDLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  scan request; accepted only in IDLE
- mask  input  8  channel enable, bit i = channel i; latched on start acceptance
- sel  output  3  mux select, drives mux8_1 Sel
- y_in  input  1  mux output Y
- frame  output  8  captured frame; bit i = sample of channel i, 0 if masked off
- frame_valid  output  1  frame available
- frame_ready  input  1  downstream accepts frame
- busy  output  1  scan in progress
- overrun  output  1  sticky flag: start seen while not in IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel=0, frame=0, frame_valid=0, busy=0, overrun=0, internal mask=0, counter=0. Reset mid-scan discards the partial frame. The first edge after release is a normal IDLE cycle.
- States: IDLE, SETTLE, HOLD.
- IDLE, start=1 at edge S:
  - Latch mask, clear frame to 0, clear overrun.
  - If mask≠0: sel<=lowest enabled channel, counter<=SETTLE_CYCLES, busy<=1, go to SETTLE.
  - If mask=0: frame_valid<=1 and frame stays 0 at edge S; go to HOLD; sel unchanged.
- SETTLE: counter decrements each edge. On the edge where counter==1:
  - frame[sel]<=y_in (value present before the edge).
  - If a higher enabled channel remains: sel<=next enabled channel, counter<=SETTLE_CYCLES, stay in SETTLE.
  - Else: busy<=0, frame_valid<=1, go to HOLD; sel holds the last channel.
- Timing: each enabled channel occupies exactly SETTLE_CYCLES cycles on sel. frame_valid rises at edge S + N*SETTLE_CYCLES, where N = number of enabled channels.
- HOLD: frame and frame_valid stable while frame_ready=0. On an edge with frame_ready=1:
  - frame_valid<=0.
  - AUTO_RESTART=0: go to IDLE.
  - AUTO_RESTART=1: same-edge restart exactly as a start acceptance, using the latched mask. frame is cleared and valid drops for at least SETTLE_CYCLES cycles. With mask=0, frame_valid re-asserts at the next edge.
- frame_ready is ignored outside HOLD. frame_valid never drops without acceptance or reset.
- start while in SETTLE or HOLD: ignored for scanning; overrun<=1 (sticky until next accepted start).
- start and frame_ready in the same HOLD cycle: frame accepted, overrun set, and start is not accepted. The request is not queued; IDLE is reached when AUTO_RESTART=0.
- mask changes after acceptance have no effect until the next accepted start.
- sel holds its value in IDLE and HOLD. It changes only in SETTLE transitions and at start acceptance.

Test Plan:
- Reset values: assert rst_n=0 mid-run -> sel=0, frame=0, frame_valid=0, busy=0, overrun=0 immediately (asynchronous). After release, no activity until start.
- Full scan: SETTLE_CYCLES=2, mask=8'hFF, bench mux data D7..D0 = 8'hA5, start at edge S:
  - sel steps 0,1,...,7, each held 2 cycles.
  - frame_valid rises at S+16 with frame=8'hA5; busy=1 from S to S+15.
- Sparse mask: mask=8'h81, D0=1, D7=1, others 0 -> sel sequence 0 then 7; frame=8'h81 valid at S+4. Same run with D0=0 -> frame=8'h80.
- Backpressure: hold frame_ready=0 for 10 cycles after valid -> frame and valid stable. Then frame_ready=1 for one edge -> frame_valid=0 at that edge, state IDLE. AUTO_RESTART=1 variant: busy=1 and sel=first channel on that same edge.
- Empty mask: mask=8'h00, start -> frame_valid=1, frame=0 at edge S, sel unchanged.
- Overrun: pulse start during SETTLE -> overrun=1 and the scan continues unaffected. The next accepted start clears overrun.

Source files
------------

// File: rtl/mux_scan_if.sv
// Scan controller bundle: mux select/sample pair, start/mask request
// and the frame valid/ready handshake.
interface mux_scan_if;
  logic       start;
  logic [7:0] mask;
  logic [2:0] sel;
  logic       y_in;
  logic [7:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;
  logic       overrun;

  modport master (
    input  start, mask, y_in, frame_ready,
    output sel, frame, frame_valid, busy, overrun
  );

  modport slave (
    output start, mask, y_in, frame_ready,
    input  sel, frame, frame_valid, busy, overrun
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps an 8:1 mux through enabled channels, samples Y after a settle
// time and offers the packed 8-bit frame on a valid/ready handshake.
module mux_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter bit AUTO_RESTART  = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  mux_scan_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] frame_q, frame_d;
  logic       fv_q, fv_d;
  logic       busy_q, busy_d;
  logic       ovr_q, ovr_d;
  logic       rearm, rearm_d;
  logic       launch;
  logic [7:0] lmask;
  logic [3:0] first_ch, next_ch;

  // Returns {found, index} of lowest enabled channel above 'after'
  // (or lowest overall when 'any' is set).
  function automatic logic [3:0] pick(
    input logic [7:0] m,
    input logic [2:0] after,
    input logic       any
  );
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (any || i > int'(after)))
        r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign next_ch  = pick(mask_q, sel_q, 1'b0);
  assign first_ch = pick(lmask, 3'd0, 1'b1);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mask_d  = mask_q;
    sel_d   = sel_q;
    frame_d = frame_q;
    fv_d    = fv_q;
    busy_d  = busy_q;
    ovr_d   = ovr_q;
    rearm_d = 1'b0;
    launch  = 1'b0;
    lmask   = bus.mask;

    unique case (state)
      IDLE: begin
        if (rearm || bus.start) begin
          launch = 1'b1;
          lmask  = rearm ? mask_q : bus.mask;
        end
      end
      SETTLE: begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) begin
          frame_d[sel_q] = bus.y_in;
          if (next_ch[3]) begin
            sel_d = next_ch[2:0];
            cnt_d = SETTLE_LD;
          end else begin
            busy_d  = 1'b0;
            fv_d    = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.frame_ready) begin
          fv_d = 1'b0;
          if (!AUTO_RESTART) begin
            state_d = IDLE;
          end else if (mask_q == 8'd0) begin
            // Empty mask: drop valid for one cycle, relaunch from IDLE.
            state_d = IDLE;
            rearm_d = 1'b1;
          end else begin
            launch = 1'b1;
            lmask  = mask_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      mask_d  = lmask;
      frame_d = 8'd0;
      ovr_d   = 1'b0;
      if (first_ch[3]) begin
        sel_d   = first_ch[2:0];
        cnt_d   = SETTLE_LD;
        busy_d  = 1'b1;
        state_d = SETTLE;
      end else begin
        fv_d    = 1'b1;
        state_d = HOLD;
      end
    end

    if (bus.start && state != IDLE)
      ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      mask_q  <= 8'd0;
      sel_q   <= 3'd0;
      frame_q <= 8'd0;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rearm   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      rearm   <= rearm_d;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = fv_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = ovr_q;

endmodule
